// File: rtl/keypad_scanner.sv
// Row-scanned key matrix reader: drives one row at a time, debounces whole-matrix
// snapshots, classifies the debounced matrix and emits press events over a
// valid/ready handshake.
module keypad_scanner #(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 4,
    parameter int unsigned DWELL    = 1000,
    parameter int unsigned DEBOUNCE = 3,
    localparam int unsigned CW      = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] cols_in,
    output logic [ROWS-1:0] rows_out,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            key_held,
    output logic            multi_key,
    output logic            overflow
);

    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned DW = $clog2(DWELL);
    localparam int unsigned SW = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ONE   = 2'd1,
        ST_MULTI = 2'd2
    } state_t;

    logic [COLS-1:0] cols_s1;
    logic [COLS-1:0] cols_s2;
    logic [DW-1:0]   dwell_cnt;
    logic [RW-1:0]   row_idx;
    logic [N-1:0]    snap;
    logic [N-1:0]    prev_snap;
    logic [N-1:0]    deb;
    logic [SW-1:0]   stable_cnt;
    state_t          state;
    state_t          state_next;

    logic            sample_c;
    logic            scan_done_c;
    logic [N-1:0]    snap_next_c;
    logic [SW-1:0]   stable_next_c;
    logic            deb_load_c;
    logic            none_c;
    logic            single_c;
    logic [CW-1:0]   code_c;
    logic            press_c;

    // Two-flop synchronizer for the asynchronous column lines
    always_ff @(posedge clk) begin
        if (rst) begin
            cols_s1 <= '0;
            cols_s2 <= '0;
        end else begin
            cols_s1 <= cols_in;
            cols_s2 <= cols_s1;
        end
    end

    assign sample_c    = (dwell_cnt == DW'(DWELL - 1));
    assign scan_done_c = sample_c && (row_idx == RW'(ROWS - 1));

    // Row dwell timing and one-hot row drive, rotated in step with the row index
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_cnt <= '0;
            row_idx   <= '0;
            rows_out  <= ROWS'(1);
        end else if (sample_c) begin
            dwell_cnt <= '0;
            row_idx   <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);
            rows_out  <= {rows_out[ROWS-2:0], rows_out[ROWS-1]};
        end else begin
            dwell_cnt <= dwell_cnt + DW'(1);
        end
    end

    // Snapshot with the current row's synchronized columns merged in
    always_comb begin
        snap_next_c = snap;
        for (int r = 0; r < int'(ROWS); r++) begin
            if (row_idx == RW'(r)) begin
                snap_next_c[r*COLS +: COLS] = cols_s2;
            end
        end
    end

    // Stable-scan count update and debounced-matrix load decision
    always_comb begin
        stable_next_c = SW'(1);
        if (snap_next_c == prev_snap) begin
            stable_next_c = (stable_cnt >= SW'(DEBOUNCE)) ? stable_cnt : stable_cnt + SW'(1);
        end
        deb_load_c = scan_done_c && (stable_next_c == SW'(DEBOUNCE));
    end

    // Key-count classification and code of the lowest set bit of the new matrix
    always_comb begin
        none_c   = (snap_next_c == '0);
        single_c = !none_c && ((snap_next_c & (snap_next_c - N'(1))) == '0);
        code_c   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (snap_next_c[i]) begin
                code_c = CW'(i);
            end
        end
    end

    // Raw snapshot capture, scan-to-scan comparison and debounced matrix
    always_ff @(posedge clk) begin
        if (rst) begin
            snap       <= '0;
            prev_snap  <= '0;
            stable_cnt <= '0;
            deb        <= '0;
        end else begin
            if (sample_c) begin
                snap <= snap_next_c;
            end
            if (scan_done_c) begin
                prev_snap  <= snap_next_c;
                stable_cnt <= stable_next_c;
            end
            if (deb_load_c) begin
                deb <= snap_next_c;
            end
        end
    end

    // Key-state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Key-state transitions on each debounced update; press only into a fresh single key
    always_comb begin
        state_next = state;
        press_c    = 1'b0;
        if (deb_load_c) begin
            if (none_c) begin
                state_next = ST_IDLE;
            end else if (single_c) begin
                state_next = ST_ONE;
                if ((state == ST_IDLE) || ((state == ST_ONE) && (snap_next_c != deb))) begin
                    press_c = 1'b1;
                end
            end else begin
                state_next = ST_MULTI;
            end
        end
    end

    // Event handshake, overflow pulse and level status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            key_held  <= (state_next == ST_ONE);
            multi_key <= (state_next == ST_MULTI);
            overflow  <= 1'b0;
            if (press_c) begin
                if (!key_valid || key_ready) begin
                    key_code  <= code_c;
                    key_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulates a key matrix on the row/column lines,
// applies directed per-scan vectors, randomized scans against a scan-level
// model, and a mid-scan reset sequence.
module tb_keypad_scanner;

    localparam int unsigned ROWS     = 4;
    localparam int unsigned COLS     = 4;
    localparam int unsigned DWELL    = 4;
    localparam int unsigned DEBOUNCE = 3;
    localparam int unsigned N        = ROWS * COLS;
    localparam int unsigned CW       = $clog2(N);
    localparam int unsigned SCAN     = ROWS * DWELL;

    logic            clk = 1'b0;
    logic            rst;
    logic [COLS-1:0] cols_in;
    logic [ROWS-1:0] rows_out;
    logic [CW-1:0]   key_code;
    logic            key_valid;
    logic            key_ready;
    logic            key_held;
    logic            multi_key;
    logic            overflow;
    logic [N-1:0]    matrix;

    int checks = 0;
    int errors = 0;
    int ovf_pulses = 0;

    typedef struct {
        logic [N-1:0]  m;
        logic          rdy;
        logic          v;
        logic [CW-1:0] code;
        logic          held;
        logic          multi;
        logic          ovf;
    } vec_t;

    vec_t tbl[$];

    // scan-level reference model state
    logic [N-1:0]  m_prev;
    logic [N-1:0]  m_deb;
    int            m_run;
    int            m_cls;
    logic          m_valid;
    logic [CW-1:0] m_code;
    logic          m_ovf;

    always #5 clk = ~clk;

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk(clk), .rst(rst), .cols_in(cols_in), .rows_out(rows_out),
        .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
        .key_held(key_held), .multi_key(multi_key), .overflow(overflow)
    );

    // Key matrix: a closed key connects its row drive to its column
    always_comb begin
        cols_in = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            if (rows_out[r]) cols_in = cols_in | matrix[r*COLS +: COLS];
        end
    end

    always @(negedge clk) begin
        if (overflow) ovf_pulses <= ovf_pulses + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int count_keys(input logic [N-1:0] m);
        int n = 0;
        for (int i = 0; i < int'(N); i++) if (m[i]) n++;
        return n;
    endfunction

    function automatic logic [CW-1:0] key_of(input logic [N-1:0] m);
        logic [CW-1:0] c = '0;
        for (int r = 0; r < int'(ROWS); r++)
            for (int c2 = 0; c2 < int'(COLS); c2++)
                if (m[r*COLS + c2]) c = CW'(r*COLS + c2);
        return c;
    endfunction

    task automatic model_reset();
        m_prev = '0; m_deb = '0; m_run = 0; m_cls = 0;
        m_valid = 1'b0; m_code = '0; m_ovf = 1'b0;
    endtask

    // One full scan of matrix m with key_ready held at r for the whole scan
    task automatic model_scan(input logic [N-1:0] m, input logic r);
        int n;
        int new_cls;
        bit press;
        m_ovf = 1'b0;
        if (r) m_valid = 1'b0;
        if (m == m_prev) m_run = (m_run < int'(DEBOUNCE)) ? m_run + 1 : int'(DEBOUNCE);
        else m_run = 1;
        m_prev = m;
        if (m_run == int'(DEBOUNCE)) begin
            n = count_keys(m);
            new_cls = (n == 0) ? 0 : (n == 1) ? 1 : 2;
            press = (new_cls == 1) && ((m_cls == 0) || ((m_cls == 1) && (m != m_deb)));
            if (press) begin
                if (m_valid) m_ovf = 1'b1;
                else begin
                    m_valid = 1'b1;
                    m_code = key_of(m);
                end
            end
            m_cls = new_cls;
            m_deb = m;
        end
    endtask

    task automatic add_vec(input int m, input int rdy, input int v, input int code,
                           input int held, input int multi, input int ovf);
        vec_t e;
        e.m = N'(m); e.rdy = (rdy != 0); e.v = (v != 0); e.code = CW'(code);
        e.held = (held != 0); e.multi = (multi != 0); e.ovf = (ovf != 0);
        tbl.push_back(e);
    endtask

    // Enter/leave at a falling edge; leaves reset released with a fresh scan starting
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; matrix = '0; key_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset rows_out", int'(rows_out), 1);
        check("reset key_valid", int'(key_valid), 0);
        check("reset key_code", int'(key_code), 0);
        check("reset key_held", int'(key_held), 0);
        check("reset multi_key", int'(multi_key), 0);
        check("reset overflow", int'(overflow), 0);
        rst = 1'b0;
        model_reset();
    endtask

    // One scan from a scan boundary to the next, checking the row drive each cycle
    task automatic run_scan(input logic [N-1:0] m, input logic r, output logic v_after1);
        logic [ROWS-1:0] exp_rows;
        matrix = m;
        key_ready = r;
        v_after1 = 1'b0;
        for (int k = 1; k <= int'(SCAN); k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_rows = ROWS'(1) << ((k / int'(DWELL)) % int'(ROWS));
            check($sformatf("rows_out cycle %0d", k), int'(rows_out), int'(exp_rows));
            if (k == 1) v_after1 = key_valid;
        end
    endtask

    task automatic scan_and_check(input logic [N-1:0] m, input logic r, input string tag);
        logic v1;
        run_scan(m, r, v1);
        model_scan(m, r);
        if (r) check({tag, " valid cleared by ready"}, int'(v1), 0);
        check({tag, " key_valid"}, int'(key_valid), int'(m_valid));
        check({tag, " key_code"}, int'(key_code), int'(m_code));
        check({tag, " key_held"}, int'(key_held), int'(m_cls == 1));
        check({tag, " multi_key"}, int'(multi_key), int'(m_cls == 2));
        check({tag, " overflow"}, int'(overflow), int'(m_ovf));
    endtask

    initial begin
        logic [N-1:0] cur;
        logic v1;
        logic rdy;
        rst = 1'b1; matrix = '0; key_ready = 1'b0;

        // matrix, ready, expected valid, code, held, multi, overflow at each scan end
        add_vec('h200, 1, 0, 0, 0, 0, 0);
        add_vec('h200, 1, 0, 0, 0, 0, 0);
        add_vec('h200, 1, 1, 9, 1, 0, 0);
        add_vec('h000, 1, 0, 9, 1, 0, 0);
        add_vec('h000, 1, 0, 9, 1, 0, 0);
        add_vec('h000, 1, 0, 9, 0, 0, 0);
        add_vec('h001, 1, 0, 9, 0, 0, 0);
        add_vec('h000, 1, 0, 9, 0, 0, 0);
        add_vec('h001, 1, 0, 9, 0, 0, 0);
        add_vec('h000, 1, 0, 9, 0, 0, 0);
        add_vec('h060, 1, 0, 9, 0, 0, 0);
        add_vec('h060, 1, 0, 9, 0, 0, 0);
        add_vec('h060, 1, 0, 9, 0, 1, 0);
        add_vec('h020, 1, 0, 9, 0, 1, 0);
        add_vec('h020, 1, 0, 9, 0, 1, 0);
        add_vec('h020, 1, 0, 9, 1, 0, 0);
        add_vec('h000, 1, 0, 9, 1, 0, 0);
        add_vec('h000, 1, 0, 9, 1, 0, 0);
        add_vec('h000, 1, 0, 9, 0, 0, 0);
        add_vec('h002, 0, 0, 9, 0, 0, 0);
        add_vec('h002, 0, 0, 9, 0, 0, 0);
        add_vec('h002, 0, 1, 1, 1, 0, 0);
        add_vec('h000, 0, 1, 1, 1, 0, 0);
        add_vec('h000, 0, 1, 1, 1, 0, 0);
        add_vec('h000, 0, 1, 1, 0, 0, 0);
        add_vec('h004, 0, 1, 1, 0, 0, 0);
        add_vec('h004, 0, 1, 1, 0, 0, 0);
        add_vec('h004, 0, 1, 1, 1, 0, 1);
        add_vec('h004, 0, 1, 1, 1, 0, 0);
        add_vec('h004, 1, 0, 1, 1, 0, 0);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            run_scan(tbl[i].m, tbl[i].rdy, v1);
            if (tbl[i].rdy) check($sformatf("vec %0d valid cleared by ready", i), int'(v1), 0);
            check($sformatf("vec %0d key_valid", i), int'(key_valid), int'(tbl[i].v));
            check($sformatf("vec %0d key_code", i), int'(key_code), int'(tbl[i].code));
            check($sformatf("vec %0d key_held", i), int'(key_held), int'(tbl[i].held));
            check($sformatf("vec %0d multi_key", i), int'(multi_key), int'(tbl[i].multi));
            check($sformatf("vec %0d overflow", i), int'(overflow), int'(tbl[i].ovf));
        end
        check("overflow pulse count", ovf_pulses, 1);

        // Randomized scans with persistent matrices so debouncing completes often
        do_reset();
        cur = '0;
        for (int s = 0; s < 80; s++) begin
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(3))
                    0: cur = '0;
                    1: cur = N'(1) << $urandom_range(N - 1);
                    2: cur = (N'(1) << $urandom_range(N - 1)) | (N'(1) << $urandom_range(N - 1));
                    default: cur = N'($urandom);
                endcase
            end
            rdy = ($urandom_range(3) != 0);
            scan_and_check(cur, rdy, $sformatf("rand %0d", s));
        end

        // Reset in the middle of row 2 while an event is pending
        do_reset();
        for (int s = 0; s < int'(DEBOUNCE); s++) scan_and_check(N'('h8), 1'b0, "pend");
        repeat (2 * DWELL + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset key_valid", int'(key_valid), 0);
        check("midreset rows_out", int'(rows_out), 1);
        check("midreset key_code", int'(key_code), 0);
        check("midreset key_held", int'(key_held), 0);
        check("midreset multi_key", int'(multi_key), 0);
        check("midreset overflow", int'(overflow), 0);
        rst = 1'b0;
        model_reset();
        for (int s = 0; s < int'(DEBOUNCE); s++) scan_and_check(N'('h8), 1'b1, $sformatf("after %0d", s));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter ROWS, default 4, number of driven rows (2..8).
REQ-002 The block SHALL have parameter COLS, default 4, number of sensed columns (2..8).
REQ-003 The block SHALL have parameter DWELL, default 1000, clock cycles each row is driven (>=4).
REQ-004 The block SHALL have parameter DEBOUNCE, default 3, consecutive identical full scans required to accept a matrix state (1..15).
REQ-005 The block SHALL use localparam CW = clog2(ROWS*COLS), the key code width.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 cols_in  input  COLS  asynchronous column sense lines, 1 = key closed on driven row.
REQ-009 rows_out  output  ROWS  one-hot active-high row drive.
REQ-010 key_code  output  CW  code of the pressed key, row*COLS+col.
REQ-011 key_valid  output  1  key_code holds an unconsumed press event.
REQ-012 key_ready  input  1  consumer accepts the event when key_valid & key_ready.
REQ-013 key_held  output  1  level: exactly one debounced key currently down.
REQ-014 multi_key  output  1  level: more than one debounced key down.
REQ-015 overflow  output  1  one-cycle pulse: press event dropped.

Function
REQ-016 cols_in SHALL pass through a 2-flop synchronizer before any use.
REQ-017 Dwell counter SHALL count 0..DWELL-1 per row; at DWELL-1, the row index SHALL advance, wrapping ROWS-1 -> 0.
REQ-018 rows_out SHALL be one-hot at the current row index at all times, including reset.
REQ-019 Synchronized columns SHALL be sampled only on dwell count DWELL-1 into the raw-snapshot bits for the current row.
REQ-020 A full scan SHALL complete on the sample of row ROWS-1; latency from row 0 drive to scan complete = ROWS*DWELL cycles.
REQ-021 At scan complete: if the snapshot equals the previous snapshot, the stable count SHALL increment (saturating at DEBOUNCE); otherwise it SHALL reset to 1.
REQ-022 When the stable count reaches DEBOUNCE, the snapshot SHALL become the debounced matrix in the same cycle.
REQ-023 State machine SHALL be IDLE (0 keys), ONE (exactly 1 key), MULTI (>=2 keys), evaluated on each debounced-matrix update.
REQ-024 IDLE->ONE SHALL generate a press event with the code of the set bit; ONE->ONE with a different key SHALL also generate a press event.
REQ-025 Any ->MULTI SHALL generate no event; MULTI->ONE SHALL NOT generate an event (release to IDLE needed first); any ->IDLE SHALL generate no event.
REQ-026 key_held SHALL be 1 exactly in ONE; multi_key SHALL be 1 exactly in MULTI.
REQ-027 A press event SHALL load key_code and set key_valid on the next cycle; key_code SHALL remain stable while key_valid=1.
REQ-028 key_valid SHALL clear the cycle after key_valid & key_ready; a same-cycle new event SHALL load instead, keeping key_valid=1.
REQ-029 A press event while key_valid=1 and key_ready=0 SHALL be dropped and overflow SHALL pulse for 1 cycle.
REQ-030 Codes SHALL be computed in CW bits; no wrap since row*COLS+col <= ROWS*COLS-1.

Reset
REQ-031 During rst=1: row index 0, rows_out = 1 at bit 0, dwell count 0, snapshots and debounced matrix all-zero, stable count 0, state IDLE.
REQ-032 During rst=1: key_code 0, key_valid 0, key_held 0, multi_key 0, overflow 0; synchronizer flops cleared.
REQ-033 rst asserted mid-scan or with key_valid=1 SHALL discard the pending event and partial scan; scanning restarts at row 0 the cycle after rst falls.

Verification
REQ-034 Defaults, DWELL=4: after reset, rows_out cycles 0001,0010,0100,1000 every 4 cycles -> wraps to 0001 at cycle 16.
REQ-035 Hold row 2/col 1 closed, key_ready=1 -> after 3 stable scans key_valid pulses 1 cycle with key_code 9, key_held=1; release -> key_held 0, no event.
REQ-036 Toggle key at row 0/col 0 every other scan -> stable count never reaches 3, no event, state IDLE.
REQ-037 Keys 5 and 6 held together -> multi_key=1, no event; drop to key 5 only -> still no event until all released.
REQ-038 key_ready=0: press key 1, release, press key 2 -> first event held (code 1), second dropped, overflow pulses once; key_code stays 1.
REQ-039 Assert rst mid-row-2 with key_valid=1 -> next cycle key_valid=0, rows_out=0001, all state cleared.
